// File: rtl/regfile_wb_sequencer_if.sv
// Write-back packet channel between the memory stage and the write-back sequencer.
// The master offers a packet; the slave (sequencer) signals when it can take one.
interface regfile_wb_sequencer_if #(
  parameter int DATA_W = 64
);
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        wb_dstE;
  logic [DATA_W-1:0] wb_valE;
  logic [3:0]        wb_dstM;
  logic [DATA_W-1:0] wb_valM;

  modport master (
    output wb_valid, wb_dstE, wb_valE, wb_dstM, wb_valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_dstE, wb_valE, wb_dstM, wb_valM,
    output wb_ready
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Serialises Y86 dual-destination write-back packets onto the register file's
// single write port (E before M, valM wins on collision) and publishes a busy scoreboard.
module regfile_wb_sequencer #(
  parameter int         DATA_W = 64,
  parameter int         NREG   = 16,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  regfile_wb_sequencer_if.slave wb,
  output logic                  rf_we,
  output logic [3:0]            rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [NREG-1:0]       busy_mask,
  output logic                  idle
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE_E = 2'd1,
    WRITE_M = 2'd2
  } seqState_t;

  seqState_t         state;
  seqState_t         firstState;
  logic [3:0]        hEAddr;
  logic [DATA_W-1:0] hEData;
  logic [3:0]        hMAddr;
  logic [DATA_W-1:0] hMData;
  logic              needE;
  logic              needM;
  logic              accept;

  // First write state of the packet currently on the input; a colliding E write is dropped.
  always_comb begin
    needE      = (wb.wb_dstE != RNONE) && (wb.wb_dstE != wb.wb_dstM);
    needM      = (wb.wb_dstM != RNONE);
    firstState = IDLE;
    if (needE)      firstState = WRITE_E;
    else if (needM) firstState = WRITE_M;
  end

  // Ready whenever the current cycle is idle or presents the packet's final write.
  assign wb.wb_ready = (state == IDLE) || (state == WRITE_M) ||
                       ((state == WRITE_E) && (hMAddr == RNONE));
  assign accept      = wb.wb_valid && wb.wb_ready;
  assign idle        = (state == IDLE);

  // NOTE: the held packet registers are ordinary flops, not a memory, so they take the
  // async reset like the state; outputs decoded from them are then defined from reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      hEAddr <= '0;
      hEData <= '0;
      hMAddr <= '0;
      hMData <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every branch sees the pre-edge state
      // and held registers, independent of statement order.
      case (state)
        IDLE:    if (accept) state <= firstState;
        WRITE_E: begin
          if (hMAddr != RNONE) state <= WRITE_M;
          else if (accept)     state <= firstState;
          else                 state <= IDLE;
        end
        WRITE_M: state <= accept ? firstState : IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        hEAddr <= wb.wb_dstE;
        hEData <= wb.wb_valE;
        hMAddr <= wb.wb_dstM;
        hMData <= wb.wb_valM;
      end
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    busy_mask = '0;
    case (state)
      WRITE_E: begin
        rf_we             = 1'b1;
        rf_waddr          = hEAddr;
        rf_wdata          = hEData;
        busy_mask[hEAddr] = 1'b1;
        if (hMAddr != RNONE) busy_mask[hMAddr] = 1'b1;
      end
      WRITE_M: begin
        rf_we             = 1'b1;
        rf_waddr          = hMAddr;
        rf_wdata          = hMData;
        busy_mask[hMAddr] = 1'b1;
      end
      default: ;
    endcase
    // The "no write" code never names a real register.
    busy_mask[RNONE] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Self-checking bench for regfile_wb_sequencer: table vectors, directed corner
// sequences and randomized traffic against a pending-write queue model.
module tb_regfile_wb_sequencer;

  localparam logic [3:0] RNONE = 4'hF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [15:0] busy_mask;
  logic        idle;

  regfile_wb_sequencer_if #(.DATA_W(64)) wbIf ();

  regfile_wb_sequencer #(.DATA_W(64), .NREG(16), .RNONE(4'hF)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wb        (wbIf.slave),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_mask (busy_mask),
    .idle      (idle)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model: an ordered list of writes still owed to the register file.
  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         pendQ[$];
  logic [63:0] refRf [16];
  logic [63:0] dutRf [16];

  // Register file as seen through the DUT's write port.
  always @(posedge clock) if (rf_we) dutRf[rf_waddr] <= rf_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic modelReady();
    return pendQ.size() <= 1;
  endfunction

  function automatic void modelAccept(input logic [3:0] dE, input logic [63:0] vE,
                                      input logic [3:0] dM, input logic [63:0] vM);
    if (dE != RNONE && dE != dM) pendQ.push_back('{addr: dE, data: vE});
    if (dM != RNONE)             pendQ.push_back('{addr: dM, data: vM});
  endfunction

  // Compare all outputs to the model; called at a falling edge.
  task automatic modelCheck(input string tag);
    logic [15:0] expBusy;
    expBusy = '0;
    foreach (pendQ[i]) expBusy[pendQ[i].addr] = 1'b1;
    check({tag, "_we"},    rf_we,   pendQ.size() > 0);
    check({tag, "_waddr"}, rf_waddr, pendQ.size() > 0 ? pendQ[0].addr : 4'd0);
    check({tag, "_wdata"}, rf_wdata, pendQ.size() > 0 ? pendQ[0].data : 64'd0);
    check({tag, "_busy"},  busy_mask, expBusy);
    check({tag, "_ready"}, wbIf.wb_ready, modelReady());
    check({tag, "_idle"},  idle, pendQ.size() == 0);
  endtask

  // Advance the model across one rising edge; returns whether the offer was taken.
  task automatic modelEdge(output logic acc);
    acc = wbIf.wb_valid && modelReady();
    @(posedge clock);
    if (pendQ.size() > 0) begin
      refRf[pendQ[0].addr] = pendQ[0].data;
      void'(pendQ.pop_front());
    end
    if (acc) modelAccept(wbIf.wb_dstE, wbIf.wb_valE, wbIf.wb_dstM, wbIf.wb_valM);
    #1;
  endtask

  task automatic cycle(input string tag);
    logic acc;
    @(negedge clock);
    modelCheck(tag);
    modelEdge(acc);
  endtask

  task automatic drive(input logic v, input logic [3:0] dE, input logic [63:0] vE,
                       input logic [3:0] dM, input logic [63:0] vM);
    wbIf.wb_valid = v;
    wbIf.wb_dstE  = dE;
    wbIf.wb_valE  = vE;
    wbIf.wb_dstM  = dM;
    wbIf.wb_valM  = vM;
  endtask

  // Offer a packet and hold it until taken (bounded); reports cycles spent offering.
  task automatic offer(input string tag, input logic [3:0] dE, input logic [63:0] vE,
                       input logic [3:0] dM, input logic [63:0] vM, output int cycles);
    logic acc;
    acc    = 1'b0;
    cycles = 0;
    drive(1'b1, dE, vE, dM, vM);
    while (!acc && cycles < 8) begin
      @(negedge clock);
      modelCheck(tag);
      modelEdge(acc);
      cycles++;
    end
    check({tag, "_taken"}, acc, 1'b1);
  endtask

  typedef struct {
    logic [3:0]  dE;
    logic [63:0] vE;
    logic [3:0]  dM;
    logic [63:0] vM;
    logic        expWe;
    logic [3:0]  expAddr;
    logic [63:0] expData;
    logic [15:0] expBusy;
    logic        expReady;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  cyc;
    logic acc;
    logic holding;

    vecs[0] = '{4'h3, 64'h11, RNONE, 64'h0,  1'b1, 4'h3, 64'h11, 16'h0008, 1'b1};
    vecs[1] = '{4'h4, 64'h20, 4'h3,  64'h99, 1'b1, 4'h4, 64'h20, 16'h0018, 1'b0};
    vecs[2] = '{4'h4, 64'h20, 4'h4,  64'h55, 1'b1, 4'h4, 64'h55, 16'h0010, 1'b1};
    vecs[3] = '{RNONE, 64'h1, RNONE, 64'h2,  1'b0, 4'h0, 64'h0,  16'h0000, 1'b1};
    vecs[4] = '{RNONE, 64'h5, 4'h7,  64'h77, 1'b1, 4'h7, 64'h77, 16'h0080, 1'b1};
    vecs[5] = '{4'h0, 64'h1,  4'hE,  64'h2,  1'b1, 4'h0, 64'h1,  16'h4001, 1'b0};
    vecs[6] = '{4'hE, 64'h3,  RNONE, 64'h0,  1'b1, 4'hE, 64'h3,  16'h4000, 1'b1};

    for (int i = 0; i < 16; i++) begin
      refRf[i] = '0;
      dutRf[i] = '0;
    end
    drive(1'b0, RNONE, '0, RNONE, '0);

    // Reset state
    #12;
    check("rst_we", rf_we, 1'b0);
    check("rst_waddr", rf_waddr, 4'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_busy", busy_mask, 16'd0);
    check("rst_idle", idle, 1'b1);
    check("rst_ready", wbIf.wb_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Table vectors, each applied from idle: first-write cycle checked against constants
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].dE, vecs[i].vE, vecs[i].dM, vecs[i].vM);
      cycle("tbl_offer");
      drive(1'b0, RNONE, '0, RNONE, '0);
      @(negedge clock);
      check($sformatf("tbl%0d_we", i),    rf_we,         vecs[i].expWe);
      check($sformatf("tbl%0d_waddr", i), rf_waddr,      vecs[i].expAddr);
      check($sformatf("tbl%0d_wdata", i), rf_wdata,      vecs[i].expData);
      check($sformatf("tbl%0d_busy", i),  busy_mask,     vecs[i].expBusy);
      check($sformatf("tbl%0d_ready", i), wbIf.wb_ready, vecs[i].expReady);
      modelCheck("tbl_model");
      modelEdge(acc);
      repeat (2) cycle("tbl_drain");
    end
    check("collision_final", dutRf[4], 64'h55);

    // Back-to-back single writes with a no-write packet in between
    offer("b2b1", 4'h1, 64'hA, RNONE, 64'h0, cyc);
    check("b2b1_cycles", cyc, 1);
    offer("b2b2", 4'h2, 64'hB, RNONE, 64'h0, cyc);
    check("b2b2_cycles", cyc, 1);
    offer("b2b3", RNONE, 64'h0, RNONE, 64'h0, cyc);
    check("b2b3_cycles", cyc, 1);
    offer("b2b4", RNONE, 64'h0, 4'h5, 64'hC, cyc);
    check("b2b4_cycles", cyc, 1);
    drive(1'b0, RNONE, '0, RNONE, '0);
    repeat (2) cycle("b2b_drain");

    // Upstream stall: single packet offered right behind a dual packet
    offer("stall_dual", 4'h6, 64'h60, 4'h8, 64'h80, cyc);
    check("stall_dual_cycles", cyc, 1);
    offer("stall_single", 4'h9, 64'h91, RNONE, 64'h0, cyc);
    check("stall_single_cycles", cyc, 2);
    @(negedge clock);
    check("stall_follow_addr", rf_waddr, 4'h9);
    check("stall_follow_we", rf_we, 1'b1);
    modelCheck("stall_follow");
    drive(1'b0, RNONE, '0, RNONE, '0);
    modelEdge(acc);
    cycle("stall_drain");

    // Reset asserted during WRITE_E of a dual packet
    offer("rst_dual", 4'hA, 64'hAAAA, 4'hB, 64'hBBBB, cyc);
    drive(1'b0, RNONE, '0, RNONE, '0);
    @(negedge clock);
    check("rstmid_we_before", rf_we, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_we_now", rf_we, 1'b0);
    check("rstmid_busy_now", busy_mask, 16'd0);
    check("rstmid_idle_now", idle, 1'b1);
    pendQ.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    repeat (2) cycle("rstmid_after");
    check("rstmid_regA", dutRf[10], 64'h0);
    check("rstmid_regB", dutRf[11], 64'h0);

    // Randomized traffic; an unaccepted packet is held stable until taken
    holding = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!holding) begin
        logic [3:0] dE;
        logic [3:0] dM;
        dE = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));
        dM = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));
        if ($urandom_range(0, 5) == 0) dM = dE;
        drive($urandom_range(0, 3) != 0, dE, {$urandom, $urandom}, dM, {$urandom, $urandom});
      end
      @(negedge clock);
      modelCheck("rand");
      modelEdge(acc);
      holding = wbIf.wb_valid && !acc;
    end
    drive(1'b0, RNONE, '0, RNONE, '0);
    repeat (3) cycle("rand_drain");

    for (int r = 0; r < 15; r++) check($sformatf("regfile_r%0d", r), dutRf[r], refRf[r]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sequencer.md
# regfile_wb_sequencer

Write-back sequencer for the Y86 register file. Accepts one write-back packet per instruction, carrying up to two destinations (dstE/valE and dstM/valM), and serialises them onto the register file's single write port. It applies the Y86 priority rule: when both destinations name the same register, valM wins. It also publishes a scoreboard of registers with pending writes, which decode uses for stall and hazard checks. It sits between the memory stage and the register file.

## Interface
- DATA_W, 64, register data width
- NREG, 16, number of architectural registers (address width 4)
- RNONE, 4'hF, destination code meaning "no write"

- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  write-back packet offered
- wb_ready  out  1  sequencer can accept a packet this cycle
- wb_dstE  in  4  E destination register, RNONE = none
- wb_valE  in  DATA_W  E write data
- wb_dstM  in  4  M destination register, RNONE = none
- wb_valM  in  DATA_W  M write data
- rf_we  out  1  register-file write enable; the register file captures on the rising edge
- rf_waddr  out  4  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- busy_mask  out  NREG  bit r set = register r has an accepted, not-yet-written update
- idle  out  1  no pending writes (state IDLE)

## Operation
- Handshake: a packet is accepted on a rising edge where wb_valid && wb_ready. Unaccepted inputs are ignored. The upstream stage holds the packet stable until it is accepted.
- On acceptance the sequencer latches hE_addr, hE_data, hM_addr and hM_data.
- E write is needed when dstE != RNONE && dstE != dstM. When dstE == dstM, the E write is dropped and only valM is written.
- M write is needed when dstM != RNONE.
- States: IDLE, WRITE_E, WRITE_M.
- IDLE, on accept: go to WRITE_E if an E write is needed; else to WRITE_M if an M write is needed; else stay in IDLE. A packet with no writes completes immediately.
- WRITE_E: if hM_addr != RNONE, go to WRITE_M. Otherwise this is the final write: go to the new packet's first state if one is accepted this edge, else to IDLE.
- WRITE_M: always the final write. Go to the new packet's first state if one is accepted, else to IDLE.
- wb_ready = IDLE || WRITE_M || (WRITE_E && hM_addr == RNONE). A new packet is accepted during the final write cycle, giving back-to-back throughput.
- Outputs are combinational from state and held registers:
  - IDLE: rf_we=0, rf_waddr=0, rf_wdata=0.
  - WRITE_E: rf_we=1, rf_waddr=hE_addr, rf_wdata=hE_data.
  - WRITE_M: rf_we=1, rf_waddr=hM_addr, rf_wdata=hM_data.
- busy_mask:
  - IDLE: 0.
  - WRITE_E: (1<<hE_addr) | (hM_addr!=RNONE ? 1<<hM_addr : 0).
  - WRITE_M: 1<<hM_addr.
  - Bit 15 is never set.
- Ordering: E is always written before M, so a popq %rsp-style collision ends with valM in the register.
- idle = (state == IDLE).

## Timing
- Reset (reset_n low, asynchronous) forces state IDLE and clears the held registers to 0. As a result: rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, idle=1, wb_ready=1.
- Reset asserted mid-operation drops all pending writes. rf_we falls immediately with reset, not at the next edge.
- The first write is presented in the cycle after the acceptance edge. The register file commits it at the end of that cycle.
- Latency, acceptance to last commit: 1 cycle for a single write, 2 cycles for a dual write.
- Throughput: one single-write packet per cycle; one dual-write packet per 2 cycles.
- Two-destination packets hold wb_ready low for exactly one cycle (the WRITE_E cycle).
- A busy_mask bit drops in the cycle after its write is presented.
- A no-write packet accepted in IDLE leaves all outputs unchanged and keeps wb_ready=1.

## Test plan
- Reset: drive reset_n=0 mid-WRITE_E. Required: rf_we=0 and busy_mask=0 at once; after release, idle=1, wb_ready=1, and no write to the pending registers.
- Single write: accept dstE=3, valE=0x11, dstM=F. Required: the next cycle shows rf_we=1, waddr=3, wdata=0x11, busy_mask=0x0008, wb_ready=1; the cycle after that, idle=1.
- Dual write (popq %rbx style): accept dstE=4/0x20, dstM=3/0x99. Required:
  - cycle 1: waddr=4, data 0x20, busy_mask=0x0018, wb_ready=0;
  - cycle 2: waddr=3, data 0x99, busy_mask=0x0008, wb_ready=1.
- Collision: accept dstE=4/0x20, dstM=4/0x55. Required: exactly one write, waddr=4, data 0x55; never any write of 0x20.
- Back-to-back: hold wb_valid=1 and offer dstE=1/0xA, then dstE=2/0xB, then a no-write packet, then dstM=5/0xC. Required: writes on consecutive cycles 1/0xA, 2/0xB; then one idle cycle with rf_we=0; then 5/0xC. wb_ready stays 1 throughout.
- Stall upstream: offer a dual packet, then a single packet immediately. Required: the second packet is accepted only on the WRITE_M edge, and its write appears in the cycle after the M write with no gap.
